// File: rtl/dyn_mem_bkgp_responder.sv
// Bank-group TCDM responder: zero-initialises one SRAM macro, then serves 1-cycle
// latency reads/writes with per-byte even parity and a saturating parity-error counter.
module dyn_mem_bkgp_responder #(
   parameter  int unsigned DATA_WIDTH    = 64,
   parameter  int unsigned ADDR_WIDTH    = 10,
   parameter  int unsigned NUM_WORDS     = 1024,
   parameter  int unsigned ERR_CNT_WIDTH = 16,
   localparam int unsigned STRB_WIDTH    = DATA_WIDTH / 8,
   localparam int unsigned SRAM_WIDTH    = DATA_WIDTH + STRB_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     tcdm_req_i,
   output logic                     tcdm_gnt_o,
   input  logic [ADDR_WIDTH-1:0]    tcdm_addr_i,
   input  logic                     tcdm_we_i,
   input  logic [DATA_WIDTH-1:0]    tcdm_wdata_i,
   input  logic [STRB_WIDTH-1:0]    tcdm_strb_i,
   output logic [DATA_WIDTH-1:0]    tcdm_rdata_o,
   output logic                     tcdm_rvalid_o,
   output logic                     tcdm_ecc_err_o,
   input  logic                     init_req_i,
   output logic                     init_done_o,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
   output logic [ADDR_WIDTH-1:0]    err_addr_o,
   output logic                     sram_req_o,
   output logic                     sram_we_o,
   output logic [ADDR_WIDTH-1:0]    sram_addr_o,
   output logic [SRAM_WIDTH-1:0]    sram_wdata_o,
   output logic [SRAM_WIDTH-1:0]    sram_bmask_o,
   input  logic [SRAM_WIDTH-1:0]    sram_rdata_i
);

   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NUM_WORDS - 1);

   typedef enum logic {ST_INIT, ST_READY} state_e;

   state_e                   r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0]    r_init_cnt, w_init_cnt_nxt;
   logic                     r_rvalid, r_rd, r_oor;
   logic [ADDR_WIDTH-1:0]    r_rsp_addr;
   logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
   logic [ADDR_WIDTH-1:0]    r_err_addr;

   logic                     w_gnt, w_accept, w_oor;
   logic [STRB_WIDTH-1:0]    w_wpar, w_rpar_err;
   logic [SRAM_WIDTH-1:0]    w_bmask;
   logic                     w_rd_rsp, w_par_err, w_cnt_err;

   assign w_gnt    = (r_state == ST_READY);
   assign w_accept = tcdm_req_i & w_gnt;
   // 32-bit compare so NUM_WORDS == 2**ADDR_WIDTH never wraps to zero
   assign w_oor    = (32'(tcdm_addr_i) >= NUM_WORDS);

   // Write-side parity/bit-mask generation and read-side parity check, per byte
   always_comb begin
      w_wpar     = '0;
      w_rpar_err = '0;
      w_bmask    = '0;
      for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
         w_wpar[k]                 = ^tcdm_wdata_i[8*k +: 8];
         w_rpar_err[k]             = (^sram_rdata_i[8*k +: 8]) ^ sram_rdata_i[DATA_WIDTH + k];
         w_bmask[8*k +: 8]         = {8{tcdm_strb_i[k]}};
         w_bmask[DATA_WIDTH + k]   = tcdm_strb_i[k];
      end
   end

   // Next-state and SRAM port decode
   always_comb begin
      w_state_nxt    = r_state;
      w_init_cnt_nxt = r_init_cnt;
      sram_req_o     = 1'b0;
      sram_we_o      = 1'b0;
      sram_addr_o    = '0;
      sram_wdata_o   = '0;
      sram_bmask_o   = '0;
      case (r_state)
         ST_INIT: begin
            sram_req_o     = 1'b1;
            sram_we_o      = 1'b1;
            sram_addr_o    = r_init_cnt;
            sram_bmask_o   = '1;
            w_init_cnt_nxt = r_init_cnt + 1'b1;
            if (r_init_cnt == LAST_WORD) begin
               w_state_nxt    = ST_READY;
               w_init_cnt_nxt = '0;
            end
         end
         ST_READY: begin
            if (w_accept && !w_oor) begin
               sram_req_o  = 1'b1;
               sram_we_o   = tcdm_we_i;
               sram_addr_o = tcdm_addr_i;
               if (tcdm_we_i) begin
                  sram_wdata_o = {w_wpar, tcdm_wdata_i};
                  sram_bmask_o = w_bmask;
               end
            end
            if (init_req_i) begin
               w_state_nxt    = ST_INIT;
               w_init_cnt_nxt = '0;
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_init_cnt_nxt;
      end
   end

   // One-stage response pipeline
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rvalid   <= 1'b0;
         r_rd       <= 1'b0;
         r_oor      <= 1'b0;
         r_rsp_addr <= '0;
      end else begin
         r_rvalid <= w_accept;
         r_rd     <= w_accept & ~tcdm_we_i;
         r_oor    <= w_accept & w_oor;
         if (w_accept) r_rsp_addr <= tcdm_addr_i;
      end
   end

   assign w_rd_rsp  = r_rvalid & r_rd;
   assign w_par_err = |w_rpar_err;
   assign w_cnt_err = w_rd_rsp & ~r_oor & w_par_err;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err_cnt  <= '0;
         r_err_addr <= '0;
      end else if (w_cnt_err) begin
         if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
         r_err_addr <= r_rsp_addr;
      end
   end

   assign tcdm_gnt_o     = w_gnt;
   assign init_done_o    = w_gnt;
   assign tcdm_rvalid_o  = r_rvalid;
   assign tcdm_rdata_o   = (w_rd_rsp && !r_oor) ? sram_rdata_i[DATA_WIDTH-1:0] : '0;
   assign tcdm_ecc_err_o = w_rd_rsp & (r_oor | w_par_err);
   assign err_cnt_o      = r_err_cnt;
   assign err_addr_o     = r_err_addr;

endmodule
